// File: rtl/clock_div_pkg.sv
// -----------------------------------------------------------------------------
// clock_div_pkg
//   Shared types and helpers for the multi-channel clock divider.
//   - CNT_WIDTH   : width of the per-channel counter and config fields
//   - cnt_t       : counter / config field type
//   - ch_cfg_t    : one channel's configuration {period, high, phase}
//   - ch_state_e  : channel FSM states
//   - clamp_cfg() : maps any requested config onto a legal one
//   - ch_width()  : width of a channel-select field for a given channel count
// -----------------------------------------------------------------------------
package clock_div_pkg;

    localparam int CNT_WIDTH = 16;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    typedef struct packed {
        cnt_t period;   // P: clk cycles per divided period
        cnt_t high;     // H: cycles div_clk is high at the start of a period
        cnt_t phase;    // counter value loaded when the channel starts
    } ch_cfg_t;

    typedef enum logic [1:0] {
        CH_IDLE     = 2'd0,
        CH_RUN      = 2'd1,
        CH_STOPPING = 2'd2
    } ch_state_e;

    // Legalise a config: the period must be at least 2, the high time must
    // leave at least one low cycle, and a phase outside the period restarts
    // the channel at 0.
    function automatic ch_cfg_t clamp_cfg(input ch_cfg_t raw);
        ch_cfg_t c;
        c.period = (raw.period < cnt_t'(2)) ? cnt_t'(2) : raw.period;
        c.high   = (raw.high == '0) ? cnt_t'(1) : raw.high;
        if (c.high >= c.period) begin
            c.high = c.period - cnt_t'(1);
        end
        c.phase  = (raw.phase >= c.period) ? '0 : raw.phase;
        return c;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage : clock_div_pkg

// File: rtl/clock_div_channel.sv
// -----------------------------------------------------------------------------
// clock_div_channel
//   One divider channel: run/stop FSM, period counter, shadow/active config
//   and the registered divided clock plus rise/fall strobes.
//
//   Ports
//     clk_pi       in   input clock, rising edge
//     rst_pi       in   synchronous active-high reset
//     cfg_we_pi    in   accepted config write for this channel (only while !pending)
//     cfg_pi       in   raw config, clamped here on accept
//     run_pi       in   run request level
//     pending_po   out  shadow config waiting to become active
//     running_po   out  channel active
//     div_clk_po   out  divided clock (1 while cnt < H)
//     div_clk_no   out  complement of div_clk_po while running, 0 while stopped
//     rise_stb_po  out  pulse on cnt == 0
//     fall_stb_po  out  pulse on cnt == H
//
//   All outputs are registered and computed from the counter value being
//   loaded on the same edge, so they line up with cnt without a cycle of lag.
// -----------------------------------------------------------------------------
module clock_div_channel
    import clock_div_pkg::*;
#(
    parameter int RESET_DIV = 2
) (
    input  logic    clk_pi,
    input  logic    rst_pi,
    input  logic    cfg_we_pi,
    input  ch_cfg_t cfg_pi,
    input  logic    run_pi,
    output logic    pending_po,
    output logic    running_po,
    output logic    div_clk_po,
    output logic    div_clk_no,
    output logic    rise_stb_po,
    output logic    fall_stb_po
);

    localparam ch_cfg_t RESET_CFG = '{
        period: cnt_t'(RESET_DIV),
        high:   cnt_t'(RESET_DIV / 2),
        phase:  '0
    };

    ch_state_e state_q, state_d;
    cnt_t      cnt_q,   cnt_d;
    ch_cfg_t   active_q, active_d;
    ch_cfg_t   shadow_q, shadow_d;
    logic      pending_q, pending_d;

    logic at_boundary;
    logic run_d;
    logic div_d;

    // Last cycle of a period while counting; every config change and every
    // stop is deferred to this point so the divided clock never glitches.
    assign at_boundary = (state_q != CH_IDLE) &&
                         (cnt_q == active_q.period - cnt_t'(1));

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;

        unique case (state_q)
            CH_IDLE: begin
                if (run_pi) begin
                    // A pending write is taken at start, and its phase with it.
                    if (pending_q) begin
                        active_d  = shadow_q;
                        pending_d = 1'b0;
                        cnt_d     = shadow_q.phase;
                    end else begin
                        cnt_d     = active_q.phase;
                    end
                    state_d = CH_RUN;
                end else if (pending_q) begin
                    // Stopped: nothing to protect, adopt the new config now.
                    active_d  = shadow_q;
                    pending_d = 1'b0;
                end
            end

            CH_RUN, CH_STOPPING: begin
                if (at_boundary) begin
                    cnt_d = '0;
                    if (pending_q) begin
                        active_d  = shadow_q;
                        pending_d = 1'b0;
                    end
                    // A run request seen at the boundary cancels any stop.
                    state_d = run_pi ? CH_RUN : CH_IDLE;
                end else begin
                    cnt_d   = cnt_q + cnt_t'(1);
                    state_d = run_pi ? CH_RUN : CH_STOPPING;
                end
            end

            default: begin
                state_d = CH_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Only accepted while nothing is pending, so it never collides with
        // the shadow-to-active transfers above.
        if (cfg_we_pi) begin
            shadow_d  = clamp_cfg(cfg_pi);
            pending_d = 1'b1;
        end
    end

    // Output values for the counter state being loaded on this edge.
    assign run_d = (state_d != CH_IDLE);
    assign div_d = run_d && (cnt_d < active_d.high);

    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            // NOTE: the config registers are a handful of flops rather than a
            // memory array, so they are reset to a known divider like the rest.
            state_q     <= CH_IDLE;
            cnt_q       <= '0;
            active_q    <= RESET_CFG;
            shadow_q    <= RESET_CFG;
            pending_q   <= 1'b0;
            running_po  <= 1'b0;
            div_clk_po  <= 1'b0;
            div_clk_no  <= 1'b0;
            rise_stb_po <= 1'b0;
            fall_stb_po <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            running_po  <= run_d;
            div_clk_po  <= div_d;
            div_clk_no  <= run_d && !div_d;
            rise_stb_po <= run_d && (cnt_d == '0);
            fall_stb_po <= run_d && (cnt_d == active_d.high);
        end
    end

    assign pending_po = pending_q;

endmodule : clock_div_channel

// File: rtl/clock_div_gen.sv
// -----------------------------------------------------------------------------
// clock_div_gen
//   NUM_CH independent clock dividers driven from clk_pi. Each channel has a
//   programmable period, high time and start phase; config writes and
//   start/stop take effect only on period boundaries.
//
//   Ports
//     clk_pi        in   input clock, rising edge
//     rst_pi        in   synchronous active-high reset
//     cfg_valid_pi  in   config write request
//     cfg_ready_po  out  write accepted when valid && ready (= !pending[ch])
//     cfg_ch_pi     in   target channel
//     cfg_period_pi in   period P
//     cfg_high_pi   in   high time H
//     cfg_phase_pi  in   start counter offset
//     run_pi        in   per-channel run request
//     running_po    out  per-channel active flag
//     div_clk_po    out  divided clocks
//     div_clk_no    out  complements while running, 0 while stopped
//     rise_stb_po   out  rise strobes
//     fall_stb_po   out  fall strobes
//
//   CNT_W is expected to equal clock_div_pkg::CNT_WIDTH, which sizes the
//   shared config struct.
// -----------------------------------------------------------------------------
module clock_div_gen
    import clock_div_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int CNT_W     = CNT_WIDTH,
    parameter  int RESET_DIV = 2,
    localparam int CH_W      = ch_width(NUM_CH)
) (
    input  logic              clk_pi,
    input  logic              rst_pi,
    input  logic              cfg_valid_pi,
    output logic              cfg_ready_po,
    input  logic [CH_W-1:0]   cfg_ch_pi,
    input  logic [CNT_W-1:0]  cfg_period_pi,
    input  logic [CNT_W-1:0]  cfg_high_pi,
    input  logic [CNT_W-1:0]  cfg_phase_pi,
    input  logic [NUM_CH-1:0] run_pi,
    output logic [NUM_CH-1:0] running_po,
    output logic [NUM_CH-1:0] div_clk_po,
    output logic [NUM_CH-1:0] div_clk_no,
    output logic [NUM_CH-1:0] rise_stb_po,
    output logic [NUM_CH-1:0] fall_stb_po
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] cfg_we;
    ch_cfg_t           cfg_raw;

    assign cfg_raw = '{period: cfg_period_pi, high: cfg_high_pi, phase: cfg_phase_pi};

    // Ready is the selected channel's !pending. A select beyond NUM_CH
    // (non-power-of-two channel counts) reads as ready and the write is
    // dropped, so a stray address can never stall the config port.
    always_comb begin
        cfg_ready_po = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch_pi == CH_W'(i)) begin
                cfg_ready_po = !pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign cfg_we[g] = cfg_valid_pi && cfg_ready_po && (cfg_ch_pi == CH_W'(g));

        clock_div_channel #(
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk_pi      (clk_pi),
            .rst_pi      (rst_pi),
            .cfg_we_pi   (cfg_we[g]),
            .cfg_pi      (cfg_raw),
            .run_pi      (run_pi[g]),
            .pending_po  (pending[g]),
            .running_po  (running_po[g]),
            .div_clk_po  (div_clk_po[g]),
            .div_clk_no  (div_clk_no[g]),
            .rise_stb_po (rise_stb_po[g]),
            .fall_stb_po (fall_stb_po[g])
        );
    end

endmodule : clock_div_gen

// File: tb/tb_clock_div_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_div_gen
//   Directed and random stimulus for clock_div_gen. The reference model keeps,
//   per channel, the active/shadow config and derives the counter as
//   (start offset + cycles elapsed) mod P; outputs follow from cnt, H and the
//   running flag.
// -----------------------------------------------------------------------------
module tb_clock_div_gen;

    localparam int NUM_CH    = 4;
    localparam int CNT_W     = 16;
    localparam int RESET_DIV = 2;
    localparam int CH_W      = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_high;
    logic [CNT_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] div_clk;
    logic [NUM_CH-1:0] div_clk_n;
    logic [NUM_CH-1:0] rise_stb;
    logic [NUM_CH-1:0] fall_stb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clock_div_gen #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .RESET_DIV (RESET_DIV)
    ) dut (
        .clk_pi        (clk),
        .rst_pi        (rst),
        .cfg_valid_pi  (cfg_valid),
        .cfg_ready_po  (cfg_ready),
        .cfg_ch_pi     (cfg_ch),
        .cfg_period_pi (cfg_period),
        .cfg_high_pi   (cfg_high),
        .cfg_phase_pi  (cfg_phase),
        .run_pi        (run),
        .running_po    (running),
        .div_clk_po    (div_clk),
        .div_clk_no    (div_clk_n),
        .rise_stb_po   (rise_stb),
        .fall_stb_po   (fall_stb)
    );

    // ---------------- reference model ----------------
    bit m_run  [NUM_CH];
    int m_off  [NUM_CH];
    int m_k    [NUM_CH];
    int m_p    [NUM_CH];
    int m_h    [NUM_CH];
    int m_ph   [NUM_CH];
    int s_p    [NUM_CH];
    int s_h    [NUM_CH];
    int s_ph   [NUM_CH];
    bit m_pend [NUM_CH];

    function automatic int m_cnt(input int i);
        return m_run[i] ? (m_off[i] + m_k[i]) % m_p[i] : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_run[i] = 0; m_off[i] = 0; m_k[i] = 0; m_pend[i] = 0;
            m_p[i] = RESET_DIV; m_h[i] = RESET_DIV / 2; m_ph[i] = 0;
            s_p[i] = RESET_DIV; s_h[i] = RESET_DIV / 2; s_ph[i] = 0;
        end
    endtask

    task automatic model_apply(input int i);
        m_p[i] = s_p[i]; m_h[i] = s_h[i]; m_ph[i] = s_ph[i];
        m_pend[i] = 0;
    endtask

    task automatic model_step();
        bit acc;
        int c, p, h, ph;
        if (rst) begin
            model_reset();
            return;
        end
        acc = cfg_valid && !m_pend[int'(cfg_ch)];
        for (int i = 0; i < NUM_CH; i++) begin
            if (!m_run[i]) begin
                if (m_pend[i]) model_apply(i);
                if (run[i]) begin
                    m_run[i] = 1; m_off[i] = m_ph[i]; m_k[i] = 0;
                end
            end else begin
                c = m_cnt(i);
                if (c == m_p[i] - 1) begin
                    if (m_pend[i]) model_apply(i);
                    m_off[i] = 0; m_k[i] = 0;
                    if (!run[i]) m_run[i] = 0;
                end else begin
                    m_k[i]++;
                end
            end
        end
        if (acc) begin
            p  = (int'(cfg_period) > 2) ? int'(cfg_period) : 2;
            h  = (int'(cfg_high) > 1) ? int'(cfg_high) : 1;
            h  = (h < p) ? h : p - 1;
            ph = (int'(cfg_phase) < p) ? int'(cfg_phase) : 0;
            s_p[int'(cfg_ch)]  = p;
            s_h[int'(cfg_ch)]  = h;
            s_ph[int'(cfg_ch)] = ph;
            m_pend[int'(cfg_ch)] = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready against the model before the edge, advance the
    // model with the inputs the DUT samples, then compare all outputs.
    task automatic tick();
        logic [NUM_CH-1:0] e_run, e_div, e_divn, e_rise, e_fall;
        int c;
        #1;
        if (!rst) check("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend[int'(cfg_ch)]});
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            c = m_cnt(i);
            e_run[i]  = m_run[i];
            e_div[i]  = m_run[i] && (c < m_h[i]);
            e_divn[i] = m_run[i] && !(c < m_h[i]);
            e_rise[i] = m_run[i] && (c == 0);
            e_fall[i] = m_run[i] && (c == m_h[i]);
        end
        check("running",  32'(running),   32'(e_run));
        check("div_clk",  32'(div_clk),   32'(e_div));
        check("div_clk_n",32'(div_clk_n), 32'(e_divn));
        check("rise_stb", 32'(rise_stb),  32'(e_rise));
        check("fall_stb", 32'(fall_stb),  32'(e_fall));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_cfg(input int ch, input int p, input int h, input int ph);
        cfg_valid = 1'b1; cfg_ch = CH_W'(ch);
        cfg_period = CNT_W'(p); cfg_high = CNT_W'(h); cfg_phase = CNT_W'(ph);
        tick();
        cfg_valid = 1'b0;
    endtask

    // Bounded wait (in model terms) until channel ch shows counter value v.
    task automatic wait_cnt(input int ch, input int v);
        int n;
        n = 0;
        while (!(m_run[ch] && m_cnt(ch) == v) && n < 40) begin
            tick();
            n++;
        end
        check("wait_cnt_timeout", {31'd0, n >= 40}, 32'd0);
    endtask

    initial begin
        logic [4:0] pat5;
        int n;
        model_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_period = '0; cfg_high = '0; cfg_phase = '0; run = '0;
        ticks(2);
        check("reset_div_clk", 32'(div_clk), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        rst = 1'b0;
        tick();
        check("reset_ready", {31'd0, cfg_ready}, 32'd1);

        // 1: default divide-by-2 on ch0
        run = 4'b0001;
        ticks(8);

        // 2: ch1 P=5 H=2 from stop, explicit 11000 pattern
        write_cfg(1, 5, 2, 0);
        tick();
        run = 4'b0011;
        pat5 = 5'b11000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("ch1_pattern_11000", {31'd0, div_clk[1]}, {31'd0, pat5[4 - (i % 5)]});
        end

        // 3: mid-period rewrite to P=3 H=1; second write held off until applied
        wait_cnt(1, 1);
        write_cfg(1, 3, 1, 0);
        cfg_valid = 1'b1; cfg_ch = 2'd1;
        cfg_period = 16'd4; cfg_high = 16'd2; cfg_phase = 16'd0;
        n = 0;
        while (m_pend[1] && n < 20) begin
            tick();
            n++;
        end
        tick();
        cfg_valid = 1'b0;
        ticks(12);

        // 4: stop at cnt=1 of P=5 finishes the period; cancel before boundary
        write_cfg(1, 5, 2, 0);
        ticks(10);
        wait_cnt(1, 1);
        run[1] = 1'b0;
        ticks(6);
        check("ch1_stopped", {31'd0, running[1]}, 32'd0);
        run[1] = 1'b1;
        ticks(2);
        wait_cnt(1, 1);
        run[1] = 1'b0;
        wait_cnt(1, 3);
        run[1] = 1'b1;
        ticks(8);
        check("ch1_stop_cancelled", {31'd0, running[1]}, 32'd1);

        // 5: clamp P=0,H=7,phase=9 -> P=2,H=1,phase=0 on ch2; phase start on ch3
        write_cfg(2, 0, 7, 9);
        write_cfg(3, 6, 3, 4);
        tick();
        run = 4'b1111;
        ticks(12);

        // 6: reset mid-period with everything running
        wait_cnt(3, 2);
        rst = 1'b1;
        tick();
        check("rst_all_running", 32'(running), 32'd0);
        check("rst_all_div", 32'(div_clk), 32'd0);
        rst = 1'b0;
        ticks(8);

        // random phase
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 11) == 0) run[c] = ~run[c];
            end
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
            cfg_period = CNT_W'($urandom_range(0, 9));
            cfg_high   = CNT_W'($urandom_range(0, 9));
            cfg_phase  = CNT_W'($urandom_range(0, 9));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_clock_div_gen
